// File: rtl/pong_match_controller_pkg.sv
// Shared definitions for the pong match sequencer: state codes, winner codes,
// score limits and a saturating score increment helper.
package pong_match_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'b000,
    S_COUNTDOWN  = 3'b001,
    S_PLAY       = 3'b010,
    S_PAUSED     = 3'b011,
    S_POINT_HOLD = 3'b100,
    S_GAME_OVER  = 3'b101
  } match_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SCORE_MAX = 7'd99;

  // Score after one more point, pinned at SCORE_MAX.
  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v == SCORE_MAX) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/pong_match_controller_bcd_score_counter.sv
// Per-player score: binary value plus a BCD ones/tens pair, saturating at 99.
module pong_match_controller_bcd_score_counter
  import pong_match_controller_pkg::*;
(
  input  logic       clk100Hz,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] value
);

  // Binary and BCD views advance together so the display never lags the win logic.
  always_ff @(posedge clk100Hz) begin
    if (reset || clear) begin
      value <= '0;
      ones  <= '0;
      tens  <= '0;
    end else if (inc && (value != SCORE_MAX)) begin
      value <= value + 7'd1;
      if (ones == BCD_MAX) begin
        ones <= '0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pong_match_controller.sv
// Match-level sequencer above the rally datapath: start handshake, countdown,
// run/pause gating, point intake with BCD scoring, serve direction, win/game-over.
// Build option: define PONG_DEUCE_EN to require a 2-point lead to win (99 always wins).
module pong_match_controller
  import pong_match_controller_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned COUNT_TICKS = 100,
  parameter int unsigned HOLD_TICKS  = 50,
  parameter int unsigned OVER_TICKS  = 300
) (
  input  logic       clk100Hz,
  input  logic       reset,
  input  logic       btn_1_up,
  input  logic       btn_1_down,
  input  logic       btn_2_up,
  input  logic       btn_2_down,
  input  logic       pause,
  input  logic       point_1,
  input  logic       point_2,
  output logic       run,
  output logic       field_clear,
  output logic       serve_left,
  output logic [1:0] countdown_val,
  output logic [3:0] score_1_ones,
  output logic [3:0] score_1_tens,
  output logic [3:0] score_2_ones,
  output logic [3:0] score_2_tens,
  output logic [1:0] winner,
  output logic [2:0] match_state
);

  localparam logic [6:0] WinS      = 7'(WIN_SCORE);
  localparam logic [8:0] CountLast = 9'(COUNT_TICKS - 1);
  localparam logic [8:0] HoldLast  = 9'(HOLD_TICKS - 1);
  localparam logic [8:0] OverT     = 9'(OVER_TICKS);

  match_state_t state;
  logic [8:0]   tick;
  logic [6:0]   score_1_bin, score_2_bin;
  logic [6:0]   next_1, next_2;
  logic         both_pressed, any_pressed, over_done;
  logic         score_clear, inc_1, inc_2;
  logic         p1_wins, p2_wins;

  assign match_state = state;

  // Button decode (active-low) and score-counter controls for this cycle.
  always_comb begin
    both_pressed = (~btn_1_up | ~btn_1_down) & (~btn_2_up | ~btn_2_down);
    any_pressed  = ~(btn_1_up & btn_1_down & btn_2_up & btn_2_down);
    over_done    = (tick >= OverT);
    score_clear  = ((state == S_IDLE) && both_pressed) ||
                   ((state == S_GAME_OVER) && over_done && any_pressed);
    inc_1        = (state == S_PLAY) && point_1 && !point_2;
    inc_2        = (state == S_PLAY) && point_2 && !point_1;
  end

  // Win decision is made on the score as it will be after this point.
  always_comb begin
    next_1 = sat_inc(score_1_bin);
    next_2 = sat_inc(score_2_bin);
`ifdef PONG_DEUCE_EN
    p1_wins = (next_1 == SCORE_MAX) ||
              ((next_1 >= WinS) && ({1'b0, next_1} >= ({1'b0, score_2_bin} + 8'd2)));
    p2_wins = (next_2 == SCORE_MAX) ||
              ((next_2 >= WinS) && ({1'b0, next_2} >= ({1'b0, score_1_bin} + 8'd2)));
`else
    p1_wins = (next_1 >= WinS);
    p2_wins = (next_2 >= WinS);
`endif
  end

  pong_match_controller_bcd_score_counter u_score_1 (
    .clk100Hz (clk100Hz),
    .reset    (reset),
    .clear    (score_clear),
    .inc      (inc_1),
    .ones     (score_1_ones),
    .tens     (score_1_tens),
    .value    (score_1_bin)
  );

  pong_match_controller_bcd_score_counter u_score_2 (
    .clk100Hz (clk100Hz),
    .reset    (reset),
    .clear    (score_clear),
    .inc      (inc_2),
    .ones     (score_2_ones),
    .tens     (score_2_tens),
    .value    (score_2_bin)
  );

  // Match FSM with registered outputs; tick is zeroed on every state entry.
  always_ff @(posedge clk100Hz) begin
    if (reset) begin
      state         <= S_IDLE;
      tick          <= '0;
      run           <= 1'b0;
      field_clear   <= 1'b0;
      serve_left    <= 1'b1;
      countdown_val <= 2'd0;
      winner        <= WIN_NONE;
    end else begin
      field_clear <= 1'b0;
      tick        <= tick + 9'd1;
      case (state)
        S_IDLE: begin
          if (both_pressed) begin
            state         <= S_COUNTDOWN;
            tick          <= '0;
            serve_left    <= 1'b1;
            field_clear   <= 1'b1;
            countdown_val <= 2'd3;
          end
        end
        S_COUNTDOWN: begin
          if (pause) begin
            tick <= tick;
          end else if (tick == CountLast) begin
            tick <= '0;
            if (countdown_val == 2'd1) begin
              state         <= S_PLAY;
              countdown_val <= 2'd0;
              run           <= 1'b1;
            end else begin
              countdown_val <= countdown_val - 2'd1;
            end
          end
        end
        S_PLAY: begin
          // A point always wins over a simultaneous pause request.
          if (point_1 && point_2) begin
            state       <= S_POINT_HOLD;
            tick        <= '0;
            run         <= 1'b0;
            field_clear <= 1'b1;
          end else if (point_1 || point_2) begin
            tick       <= '0;
            run        <= 1'b0;
            serve_left <= point_2;
            if (point_1 ? p1_wins : p2_wins) begin
              state  <= S_GAME_OVER;
              winner <= point_1 ? WIN_P1 : WIN_P2;
            end else begin
              state       <= S_POINT_HOLD;
              field_clear <= 1'b1;
            end
          end else if (pause) begin
            state <= S_PAUSED;
            tick  <= '0;
            run   <= 1'b0;
          end
        end
        S_POINT_HOLD: begin
          if (tick == HoldLast) begin
            state <= S_PLAY;
            tick  <= '0;
            run   <= 1'b1;
          end
        end
        S_PAUSED: begin
          if (!pause) begin
            state         <= S_COUNTDOWN;
            tick          <= '0;
            countdown_val <= 2'd3;
          end
        end
        S_GAME_OVER: begin
          // Tick parks at the lockout limit so it cannot wrap back into lockout.
          if (over_done) begin
            tick <= tick;
            if (any_pressed) begin
              state  <= S_IDLE;
              tick   <= '0;
              winner <= WIN_NONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tick  <= '0;
          run   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_controller.sv
// Scoreboard bench for pong_match_controller: the stimulus process predicts every
// change of the packed output vector (value and cycle) from the match rules; a
// monitor compares each observed change against the next predicted one.
module tb_pong_match_controller;

  localparam int unsigned Win   = 11;
  localparam int unsigned Count = 100;
  localparam int unsigned Hold  = 50;
  localparam int unsigned Over  = 300;

  localparam logic [2:0] StIdle  = 3'b000;
  localparam logic [2:0] StCd    = 3'b001;
  localparam logic [2:0] StPlay  = 3'b010;
  localparam logic [2:0] StPause = 3'b011;
  localparam logic [2:0] StHold  = 3'b100;
  localparam logic [2:0] StOver  = 3'b101;

  logic clk100Hz, reset;
  logic btn_1_up, btn_1_down, btn_2_up, btn_2_down;
  logic pause, point_1, point_2;
  logic run, field_clear, serve_left;
  logic [1:0] countdown_val, winner;
  logic [3:0] score_1_ones, score_1_tens, score_2_ones, score_2_tens;
  logic [2:0] match_state;

  pong_match_controller #(
    .WIN_SCORE   (Win),
    .COUNT_TICKS (Count),
    .HOLD_TICKS  (Hold),
    .OVER_TICKS  (Over)
  ) dut (
    .clk100Hz      (clk100Hz),
    .reset         (reset),
    .btn_1_up      (btn_1_up),
    .btn_1_down    (btn_1_down),
    .btn_2_up      (btn_2_up),
    .btn_2_down    (btn_2_down),
    .pause         (pause),
    .point_1       (point_1),
    .point_2       (point_2),
    .run           (run),
    .field_clear   (field_clear),
    .serve_left    (serve_left),
    .countdown_val (countdown_val),
    .score_1_ones  (score_1_ones),
    .score_1_tens  (score_1_tens),
    .score_2_ones  (score_2_ones),
    .score_2_tens  (score_2_tens),
    .winner        (winner),
    .match_state   (match_state)
  );

  initial begin
    clk100Hz = 1'b0;
    forever #5 clk100Hz = ~clk100Hz;
  end

  int unsigned cyc = 0;
  always @(posedge clk100Hz) cyc <= cyc + 1;

  typedef struct packed {
    logic [25:0] v;
    int unsigned c;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  bit done_req = 1'b0;
  bit done_ack = 1'b0;

  // Reference model of the visible match state.
  logic [2:0] m_st;
  bit         m_run, m_fc, m_serve;
  int         m_cd, m_s1, m_s2;
  logic [1:0] m_win;
  bit         game_done;

  function automatic logic [25:0] pack(input logic [2:0] st, input bit rn, input bit fc,
                                       input bit sv, input int cd, input int s1, input int s2,
                                       input logic [1:0] w);
    logic [3:0] t1, o1, t2, o2;
    t1 = 4'(s1 / 10);
    o1 = 4'(s1 % 10);
    t2 = 4'(s2 / 10);
    o2 = 4'(s2 % 10);
    return {st, rn, fc, sv, 2'(cd), t1, o1, t2, o2, w};
  endfunction

  function automatic bit wins(input int me, input int other);
`ifdef PONG_DEUCE_EN
    return ((me >= int'(Win)) && (me - other >= 2)) || (me == 99);
`else
    return me >= int'(Win);
`endif
  endfunction

  task automatic push(input int unsigned c);
    exp_t e;
    e.v = pack(m_st, m_run, m_fc, m_serve, m_cd, m_s1, m_s2, m_win);
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_st = StIdle; m_run = 0; m_fc = 0; m_serve = 1; m_cd = 0;
    m_s1 = 0; m_s2 = 0; m_win = 2'b00;
  endtask

  task automatic step();
    @(posedge clk100Hz);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) step();
  endtask

  // Countdown entered at edge t; an optional pause shifts every later step.
  task automatic run_countdown(input int unsigned t, input bit with_clear);
    int unsigned ps, k;
    ps = 0;
    k  = 0;
    m_st = StCd; m_run = 0; m_cd = 3; m_fc = with_clear;
    push(t);
    if (with_clear) begin
      m_fc = 0;
      push(t + 1);
    end
    if ($urandom_range(0, 1) == 1) begin
      ps = $urandom_range(2, 80);
      k  = $urandom_range(1, 15);
    end
    m_cd = 2; push(t + Count + k);
    m_cd = 1; push(t + 2 * Count + k);
    m_st = StPlay; m_cd = 0; m_run = 1;
    push(t + 3 * Count + k);
    if (k != 0) begin
      wait_until(t + ps);
      pause = 1;
      wait_until(t + ps + k);
      pause = 0;
    end
    wait_until(t + ps + k + 5);
    point_1 = 1;
    step();
    point_1 = 0;
    wait_until(t + 3 * Count + k);
  endtask

  task automatic start_game(input bit directed);
    int unsigned t, b;
    game_done = 0;
    // One player alone cannot start a match.
    btn_1_down = 0;
    step();
    btn_1_down = 1;
    step();
    b = directed ? 32'd1 : $urandom_range(0, 3);
    if (b[0]) btn_1_up = 0; else btn_1_down = 0;
    if (b[1] || directed) btn_2_down = 0; else btn_2_up = 0;
    t = cyc + 1;
    step();
    {btn_1_up, btn_1_down, btn_2_up, btn_2_down} = 4'b1111;
    m_s1 = 0; m_s2 = 0; m_serve = 1; m_win = 2'b00;
    run_countdown(t, 1'b1);
  endtask

  task automatic game_over(input int unsigned t);
    int unsigned r, tt, b;
    // Presses inside the lockout are ignored, including the last locked edge.
    wait_until(t + $urandom_range(1, 200));
    btn_2_up = 0;
    step();
    btn_2_up = 1;
    wait_until(t + Over - 1);
    btn_1_down = 0;
    step();
    btn_1_down = 1;
    r = $urandom_range(0, 20);
    wait_until(t + Over + r);
    b = $urandom_range(0, 3);
    case (b)
      0: btn_1_up = 0;
      1: btn_1_down = 0;
      2: btn_2_up = 0;
      default: btn_2_down = 0;
    endcase
    tt = cyc + 1;
    step();
    {btn_1_up, btn_1_down, btn_2_up, btn_2_down} = 4'b1111;
    m_st = StIdle; m_s1 = 0; m_s2 = 0; m_win = 2'b00; m_run = 0; m_cd = 0;
    push(tt);
    game_done = 1;
  endtask

  task automatic do_point(input bit p1, input bit p2, input bit pz);
    int unsigned t;
    point_1 = p1; point_2 = p2; pause = pz;
    t = cyc + 1;
    step();
    point_1 = 0; point_2 = 0; pause = 0;
    if (p1 && !p2) begin
      m_s1 = (m_s1 < 99) ? m_s1 + 1 : 99;
      m_serve = 0;
      if (wins(m_s1, m_s2)) m_win = 2'b01;
    end else if (p2 && !p1) begin
      m_s2 = (m_s2 < 99) ? m_s2 + 1 : 99;
      m_serve = 1;
      if (wins(m_s2, m_s1)) m_win = 2'b10;
    end
    m_run = 0;
    if (m_win != 2'b00) begin
      m_st = StOver;
      push(t);
      game_over(t);
    end else begin
      m_st = StHold; m_fc = 1; push(t);
      m_fc = 0; push(t + 1);
      m_st = StPlay; m_run = 1; push(t + Hold);
      wait_until(t + $urandom_range(2, 45));
      point_2 = 1;
      step();
      point_2 = 0;
      wait_until(t + Hold);
    end
  endtask

  task automatic do_pause();
    int unsigned t, k;
    k = $urandom_range(2, 30);
    pause = 1;
    t = cyc + 1;
    step();
    m_st = StPause; m_run = 0;
    push(t);
    point_1 = 1;
    step();
    point_1 = 0;
    wait_until(t + k - 1);
    pause = 0;
    run_countdown(t + k, 1'b0);
  endtask

  task automatic play_until_over();
    int unsigned r;
    while (!game_done && cyc < 80000) begin
      wait_until(cyc + $urandom_range(0, 15));
      r = $urandom_range(0, 99);
      if (r < 40) do_point(1, 0, 0);
      else if (r < 80) do_point(0, 1, 0);
      else if (r < 88) do_point(1, 1, 0);
      else if (r < 94) do_pause();
      else do_point(r[0], !r[0], 1);
    end
  endtask

  // Monitor: every change of the output vector must match the next prediction.
  initial begin : monitor
    logic [25:0] cur, prev_v;
    exp_t e;
    prev_v = '0;
    forever begin
      @(negedge clk100Hz);
      cur = {match_state, run, field_clear, serve_left, countdown_val,
             score_1_tens, score_1_ones, score_2_tens, score_2_ones, winner};
      if (cur !== prev_v) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change actual=%h@cyc%0d required=no change", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.v || cyc != e.c) begin
            errors++;
            $display("FAIL output_event actual=%h@cyc%0d required=%h@cyc%0d",
                     cur, cyc, e.v, e.c);
          end
        end
        prev_v = cur;
      end
      if (done_req && !done_ack) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL pending_events actual=%0d required=0 next=%h@cyc%0d",
                   exp_q.size(), exp_q[0].v, exp_q[0].c);
        end
        done_ack = 1'b1;
      end
    end
  end

  initial begin : stimulus
    int unsigned t;
    reset = 1;
    {btn_1_up, btn_1_down, btn_2_up, btn_2_down} = 4'b1111;
    pause = 0; point_1 = 0; point_2 = 0;
    model_reset();
    push(1);
    repeat (3) step();
    reset = 0;
    step();

    // Reset in the middle of a countdown returns everything to reset values.
    btn_1_up = 0; btn_2_up = 0;
    t = cyc + 1;
    step();
    {btn_1_up, btn_1_down, btn_2_up, btn_2_down} = 4'b1111;
    m_st = StCd; m_cd = 3; m_fc = 1; push(t);
    m_fc = 0; push(t + 1);
    m_cd = 2; push(t + Count);
    wait_until(t + 150);
    reset = 1;
    step();
    reset = 0;
    model_reset();
    push(t + 151);
    repeat (5) step();

    // Directed opening: 10-10 exercises BCD carry and the deuce/no-deuce decision.
    start_game(1'b1);
    repeat (10) do_point(0, 1, 0);
    repeat (10) do_point(1, 0, 0);
    do_point(1, 0, 0);
    if (!game_done) do_point(1, 0, 0);
    play_until_over();

    repeat (3) begin
      repeat ($urandom_range(1, 10)) step();
      start_game(1'b0);
      play_until_over();
    end

    repeat (5) step();
    done_req = 1'b1;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
